simple_ram_ctrl: RTL
====================

// Module: simple_ram_ctrl
// PURPOSE
//  Request/response front-end placed directly upstream of the simpleRAM storage block.
//  Accepts one read or write request at a time on a valid/ready interface.
//  Drives the RAM's we/re/addr strobes and its shared bidirectional data bus.
//  Returns read data, or a write acknowledge, on a valid/ready response channel.
// PARAMETERS
//  WORD_SIZE   8   data word width in bits; must match the RAM's word size
//  ADDR_WIDTH  5   address width in bits
//  DEPTH       32  number of implemented words; any address >= DEPTH is out of range
// PORTS
//  clk        in     1           single clock; all logic is posedge-triggered
//  rst_n      in     1           asynchronous, active-low reset
//  req_valid  in     1           request present
//  req_ready  out    1           controller can accept a request
//  req_write  in     1           1 = write, 0 = read
//  req_addr   in     ADDR_WIDTH  word address
//  req_wdata  in     WORD_SIZE   write data
//  rsp_valid  out    1           response present
//  rsp_ready  in     1           consumer accepts the response
//  rsp_rdata  out    WORD_SIZE   read data; 0 for write and error responses
//  rsp_err    out    1           1 = address was out of range; the RAM was not accessed
//  ram_we     out    1           RAM write enable
//  ram_re     out    1           RAM read enable
//  ram_addr   out    ADDR_WIDTH  RAM address
//  ram_data   inout  WORD_SIZE   shared RAM data bus; controller drives it only during WR
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; req_ready, rsp_valid, rsp_err, ram_we, ram_re = 0.
//   rsp_rdata and ram_addr = 0; ram_data = 'z.
//   Reset asserted mid-operation aborts the transfer immediately: strobes drop and the bus releases.
//  A request is accepted on the posedge where req_valid && req_ready.
//   write, addr and wdata are registered at that edge.
//  FSM states: IDLE, WR, RD_REQ, RD_CAP, RESP.
//   IDLE:   req_ready=1. On accept:
//           - addr >= DEPTH: go to RESP with rsp_err=1.
//           - else write: go to WR.
//           - else read: go to RD_REQ.
//   WR:     ram_we=1, ram_addr=addr, ram_data=wdata, for exactly 1 cycle; then RESP.
//   RD_REQ: ram_re=1, ram_addr=addr, ram_data='z, for 1 cycle; then RD_CAP.
//   RD_CAP: strobes 0, ram_data='z; the RAM drives the bus this cycle.
//           ram_data is captured into rsp_rdata at the end of this cycle; then RESP.
//   RESP:   rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
//           The handshake edge clears rsp_valid, rsp_err and rsp_rdata; go to IDLE.
//  req_ready=0 in every state except IDLE. There is no request buffering and no overlap.
//  Latency from the accept edge to first rsp_valid cycle:
//   write = 2 cycles, read = 3 cycles, error = 1 cycle.
//  Bus turnaround: RESP lasts at least 1 cycle, so a write never drives ram_data
//   in the cycle after RD_CAP. No bus contention is allowed in any sequence.
//  ram_we and ram_re are never high together; both are 0 outside WR and RD_REQ.
//  ram_addr holds its last value when idle; the RAM ignores it while strobes are 0.
//  Strobes are registered: glitch-free and aligned to clk.
//  Address compare is unsigned. DEPTH = 2**ADDR_WIDTH leaves no out-of-range addresses.
// TESTING
//  1. Write addr=3, data=8'hA5:
//     ram_we=1 for exactly 1 cycle with ram_addr=3 and ram_data=A5;
//     rsp_valid 2 cycles after accept with rsp_err=0 and rsp_rdata=0.
//  2. Read addr=3 after test 1, against a RAM model:
//     ram_re 1 cycle; rsp_rdata=8'hA5 3 cycles after accept.
//  3. Read addr=40 with DEPTH=32, ADDR_WIDTH=6:
//     rsp_err=1 one cycle after accept; ram_we and ram_re never asserted.
//  4. Hold rsp_ready=0 for 5 cycles after a read:
//     rsp_valid and rsp_rdata stay stable; req_ready=0; a second req_valid is not accepted.
//  5. Back-to-back read then write, with rsp_ready=1:
//     the bus is never driven by both sides at once (checker on ram_data 'x);
//     the write data lands correctly.
//  6. Assert rst_n=0 during RD_REQ:
//     ram_re, rsp_valid and req_ready drop to 0 without a clock edge;
//     ram_data='z; the next request after release completes normally.

Source files
------------

// File: rtl/simple_ram_ctrl.sv
// rtl/simple_ram_ctrl.sv - request/response front-end driving a simpleRAM we/re/addr strobes and shared data bus
`timescale 1ns/1ps
module simple_ram_ctrl #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]  req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_SIZE-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [WORD_SIZE-1:0]  ram_data
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR     = 3'd1;
    localparam logic [2:0] RD_REQ = 3'd2;
    localparam logic [2:0] RD_CAP = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and never matches.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 drive_en;
    logic                 accept;
    logic                 addr_oor;

    assign accept   = req_valid && req_ready;
    assign addr_oor = {1'b0, req_addr} >= DEPTH_W;

    // Bus is driven only while the registered write strobe is high.
    assign ram_data = drive_en ? wdata_q : {WORD_SIZE{1'bz}};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (addr_oor) begin
                        state_nxt = RESP;
                    end else if (req_write) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
            end
            WR:      state_nxt = RESP;
            RD_REQ:  state_nxt = RD_CAP;
            RD_CAP:  state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_addr  <= '0;
            wdata_q   <= '0;
            drive_en  <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            ram_we    <= (state_nxt == WR);
            ram_re    <= (state_nxt == RD_REQ);
            drive_en  <= (state_nxt == WR);

            if (state == IDLE && accept) begin
                wdata_q <= req_wdata;
                if (addr_oor) begin
                    rsp_err <= 1'b1;
                end else begin
                    ram_addr <= req_addr;
                end
            end

            // The RAM drives the bus for the whole of RD_CAP; sample it at the closing edge.
            if (state == RD_CAP) begin
                rsp_rdata <= ram_data;
            end

            if (state == RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule
